// File: rtl/serial_debug_mc.sv
// serial_debug_mc: store-and-forward node on the serial debug ring with CHANNELS probe/control registers.
// Latency: a frame is decoded the cycle after its last bit is sampled; retransmission starts the next cycle.
// Backpressure: none on the link; a frame completing while tx is busy is dropped (SERIAL_DEBUG_MC_STATUS_EN adds status counters).
module serial_debug_mc #(
    parameter int BITS     = 128,
    parameter int CHANNELS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 prescaler,
    input  logic                       rx_data,
    input  logic                       rx_clk,
    output logic                       tx_data,
    output logic                       tx_clk,
    input  logic [BITS-1:0]            identity,
    input  logic [CHANNELS*BITS-1:0]   debug_outgoing_data,
    output logic [CHANNELS*BITS-1:0]   debug_incoming_data,
    output logic [CHANNELS-1:0]        debug_incoming_tgl,
    output logic [14:0]                node_address,
    output logic                       address_valid
);
    localparam int         F   = BITS + 24;
    localparam int         CW  = $clog2(F + 1);
    localparam logic [7:0] NCH = 8'(CHANNELS);

    typedef enum logic [1:0] {TX_IDLE, TX_LOW, TX_HIGH} tx_state_t;

    // Receive side
    logic            rxc_m, rxc_s, rxc_p, rxd_m, rxd_s;
    logic            rx_rise;
    logic [F-1:0]    rx_sh;
    logic [CW-1:0]   rx_cnt;
    logic [14:0]     idle_cnt;
    logic [14:0]     idle_lim;
    logic            dec_vld;

    // Decode
    logic            hdr_w;
    logic [14:0]     hdr_addr;
    logic [7:0]      hdr_sel;
    logic [BITS-1:0] rx_pay;
    logic [BITS-1:0] tx_pay;
    logic [BITS-1:0] chan_rd;
    logic            is_enum, hit, sel_ok, do_enum, do_write;
    logic [F-1:0]    dec_frame;

    // Transmit side
    tx_state_t       tx_state, tx_state_nx;
    logic [F-1:0]    tx_sh;
    logic [7:0]      tx_pre;
    logic [7:0]      ph_cnt;
    logic [CW-1:0]   tx_left;
    logic            phase_end, last_bit, tx_finish, bit_next, tx_free, tx_load;

`ifdef SERIAL_DEBUG_MC_STATUS_EN
    logic [7:0]      drop_count;
    logic [15:0]     write_count;
`endif

    assign rx_rise  = rxc_s & ~rxc_p;
    // Timeout after 64 link half-bits without a clock edge
    assign idle_lim = {1'b0, prescaler, 6'b0} + 15'd64;

    // Synchronise the upstream link, shift in bits and discard stalled partial frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxc_m    <= 1'b0;
            rxc_s    <= 1'b0;
            rxc_p    <= 1'b0;
            rxd_m    <= 1'b0;
            rxd_s    <= 1'b0;
            rx_sh    <= '0;
            rx_cnt   <= '0;
            idle_cnt <= '0;
            dec_vld  <= 1'b0;
        end else begin
            rxc_m   <= rx_clk;
            rxc_s   <= rxc_m;
            rxc_p   <= rxc_s;
            rxd_m   <= rx_data;
            rxd_s   <= rxd_m;
            dec_vld <= 1'b0;
            if (rx_rise) begin
                rx_sh    <= {rx_sh[F-2:0], rxd_s};
                idle_cnt <= '0;
                if (rx_cnt == CW'(F - 1)) begin
                    rx_cnt  <= '0;
                    dec_vld <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end else if (rx_cnt != '0) begin
                if (idle_cnt == idle_lim - 15'd1) begin
                    rx_cnt   <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 15'd1;
                end
            end
        end
    end

    // Decode the received frame and build the frame to forward
    always_comb begin
        hdr_w    = rx_sh[0];
        hdr_addr = rx_sh[15:1];
        hdr_sel  = rx_sh[23:16];
        rx_pay   = rx_sh[F-1:24];
        chan_rd  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (hdr_sel == 8'(k + 1)) begin
                chan_rd = debug_outgoing_data[k*BITS +: BITS];
            end
        end
        is_enum  = (hdr_addr == 15'h7FFF);
        hit      = address_valid && (hdr_addr == node_address);
        sel_ok   = (hdr_sel != 8'd0) && (hdr_sel <= NCH);
        do_enum  = dec_vld && is_enum && (rx_pay[14:0] != 15'h7FFF);
        do_write = dec_vld && hdr_w && hit && sel_ok;
        tx_pay   = rx_pay;
        if (is_enum) begin
            tx_pay[14:0] = rx_pay[14:0] + 15'd1;
        end else if (hit && !hdr_w) begin
            if (hdr_sel == 8'h00) begin
                tx_pay = identity;
            end else if (sel_ok) begin
                tx_pay = chan_rd;
            end
`ifdef SERIAL_DEBUG_MC_STATUS_EN
            else if (hdr_sel == 8'hFE) begin
                tx_pay       = '0;
                tx_pay[31:0] = {NCH, drop_count, write_count};
            end
`endif
        end
        dec_frame = {tx_pay, rx_sh[23:0]};
    end

    // Tx bit sequencer: next state and load/finish decisions
    always_comb begin
        phase_end   = (ph_cnt == tx_pre);
        last_bit    = (tx_left == '0);
        tx_finish   = (tx_state == TX_HIGH) && phase_end && last_bit;
        bit_next    = (tx_state == TX_HIGH) && phase_end && !last_bit;
        // A finishing transmitter can accept the new frame in the same cycle
        tx_free     = (tx_state == TX_IDLE) || tx_finish;
        tx_load     = dec_vld && tx_free;
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE: tx_state_nx = TX_IDLE;
            TX_LOW:  if (phase_end) tx_state_nx = TX_HIGH;
            TX_HIGH: if (phase_end) tx_state_nx = last_bit ? TX_IDLE : TX_LOW;
            default: tx_state_nx = TX_IDLE;
        endcase
        if (tx_load) tx_state_nx = TX_LOW;
    end

    // Tx state register, shift register and registered link outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_clk   <= 1'b0;
            tx_data  <= 1'b0;
            tx_sh    <= '0;
            tx_pre   <= '0;
            ph_cnt   <= '0;
            tx_left  <= '0;
        end else begin
            tx_state <= tx_state_nx;
            tx_clk   <= (tx_state_nx == TX_HIGH);
            if (tx_load) begin
                tx_data <= dec_frame[F-1];
                tx_sh   <= {dec_frame[F-2:0], 1'b0};
                tx_left <= CW'(F - 1);
                tx_pre  <= prescaler;
                ph_cnt  <= '0;
            end else if (bit_next) begin
                tx_data <= tx_sh[F-1];
                tx_sh   <= {tx_sh[F-2:0], 1'b0};
                tx_left <= tx_left - CW'(1);
                tx_pre  <= prescaler;
                ph_cnt  <= '0;
            end else if (tx_finish) begin
                tx_data <= 1'b0;
                ph_cnt  <= '0;
            end else if (tx_state != TX_IDLE) begin
                ph_cnt <= phase_end ? 8'd0 : ph_cnt + 8'd1;
            end
        end
    end

    // Address claim and channel register writes take effect in the decode cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_address        <= '0;
            address_valid       <= 1'b0;
            debug_incoming_data <= '0;
            debug_incoming_tgl  <= '0;
        end else begin
            if (do_enum) begin
                node_address  <= rx_pay[14:0];
                address_valid <= 1'b1;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (do_write && (hdr_sel == 8'(k + 1))) begin
                    debug_incoming_data[k*BITS +: BITS] <= rx_pay;
                    debug_incoming_tgl[k]               <= ~debug_incoming_tgl[k];
                end
            end
        end
    end

`ifdef SERIAL_DEBUG_MC_STATUS_EN
    // Status counters: saturating drops, wrapping accepted writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count  <= '0;
            write_count <= '0;
        end else begin
            if (dec_vld && !tx_free && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
            if (do_write) write_count <= write_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_debug_mc.sv
// tb_serial_debug_mc: drives frames into serial_debug_mc and checks forwarded frames and registers.
// Latency: each frame is sent, then its retransmission is awaited before the next frame.
// Backpressure: frames are serialised so the node never has to drop one.
module tb_serial_debug_mc;
    localparam int BITS = 128;
    localparam int CH   = 4;
    localparam int F    = BITS + 24;
    localparam int W    = CH * BITS;
    typedef logic [F-1:0] frame_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      prescaler = 8'd2;
    logic            rx_data = 1'b0;
    logic            rx_clk = 1'b0;
    logic            tx_data, tx_clk;
    logic [BITS-1:0] identity;
    logic [W-1:0]    debug_outgoing_data;
    logic [W-1:0]    debug_incoming_data;
    logic [CH-1:0]   debug_incoming_tgl;
    logic [14:0]     node_address;
    logic            address_valid;

    always #5 clk = ~clk;

    serial_debug_mc #(.BITS(BITS), .CHANNELS(CH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .prescaler           (prescaler),
        .rx_data             (rx_data),
        .rx_clk              (rx_clk),
        .tx_data             (tx_data),
        .tx_clk              (tx_clk),
        .identity            (identity),
        .debug_outgoing_data (debug_outgoing_data),
        .debug_incoming_data (debug_incoming_data),
        .debug_incoming_tgl  (debug_incoming_tgl),
        .node_address        (node_address),
        .address_valid       (address_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [14:0]     m_addr;
    logic            m_valid;
    logic [BITS-1:0] m_in [CH];
    logic [CH-1:0]   m_tgl;
    int              m_wcount;

    task automatic model_reset();
        m_addr = '0;
        m_valid = 1'b0;
        m_tgl = '0;
        m_wcount = 0;
        for (int i = 0; i < CH; i++) m_in[i] = '0;
    endtask

    // Node behaviour from the frame rules: returns the frame expected downstream
    task automatic model(input frame_t f, output frame_t exp);
        logic            w;
        logic [14:0]     a;
        int              sel;
        logic [BITS-1:0] pay;
        w   = f[0];
        a   = f[15:1];
        sel = int'(f[23:16]);
        pay = f[F-1:24];
        if (a == 15'h7FFF) begin
            if (pay[14:0] != 15'h7FFF) begin
                m_addr  = pay[14:0];
                m_valid = 1'b1;
            end
            pay[14:0] = pay[14:0] + 15'd1;
        end else if (m_valid && a == m_addr) begin
            if (!w) begin
                if (sel == 0) pay = identity;
                else if (sel <= CH) pay = debug_outgoing_data[(sel-1)*BITS +: BITS];
`ifdef SERIAL_DEBUG_MC_STATUS_EN
                else if (sel == 254) begin
                    pay = '0;
                    pay[31:0] = {8'(CH), 8'd0, 16'(m_wcount)};
                end
`endif
            end else if (sel >= 1 && sel <= CH) begin
                m_in[sel-1]  = pay;
                m_tgl[sel-1] = ~m_tgl[sel-1];
                m_wcount++;
            end
        end
        exp = {pay, f[23:0]};
    endtask

    function automatic logic [W-1:0] model_bus();
        logic [W-1:0] b;
        for (int i = 0; i < CH; i++) b[i*BITS +: BITS] = m_in[i];
        return b;
    endfunction

    function automatic frame_t mk(input logic [BITS-1:0] p, input logic [7:0] s, input logic [14:0] a, input logic w);
        return {p, s, a, w};
    endfunction

    function automatic logic [BITS-1:0] rand_pay();
        logic [BITS-1:0] p;
        for (int j = 0; j < BITS/32; j++) p[j*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic rand_inputs();
        identity = rand_pay();
        for (int i = 0; i < CH; i++) debug_outgoing_data[i*BITS +: BITS] = rand_pay();
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_in"},    debug_incoming_data, model_bus());
        check_val({tag, "_tgl"},   W'(debug_incoming_tgl), W'(m_tgl));
        check_val({tag, "_addr"},  W'(node_address), W'(m_addr));
        check_val({tag, "_valid"}, W'(address_valid), W'(m_valid));
    endtask

    // Downstream capture: frames on tx_clk rising edges, plus link timing checks
    frame_t cap_q [$];
    frame_t cap_sh = '0;
    int     cap_n = 0;
    int     tx_viol = 0;
    int     hi_len = 0;
    logic   prev_c = 1'b0;
    logic   prev_d = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_c = 1'b0;
                prev_d = 1'b0;
                hi_len = 0;
                cap_n  = 0;
            end else begin
                if (tx_clk) begin
                    if (!prev_c) begin
                        cap_sh = {cap_sh[F-2:0], tx_data};
                        cap_n++;
                        if (cap_n == F) begin
                            cap_q.push_back(cap_sh);
                            cap_n = 0;
                        end
                        hi_len = 1;
                    end else begin
                        hi_len++;
                        if (tx_data != prev_d) tx_viol++;
                    end
                end else if (prev_c && hi_len != int'(prescaler) + 1) begin
                    tx_viol++;
                end
                prev_c = tx_clk;
                prev_d = tx_data;
            end
        end
    end

    // Upstream driver: MSB first, 3 clk low then 3 clk high per bit
    task automatic send_bits(input frame_t f, input int n);
        for (int i = F - 1; i >= F - n; i--) begin
            @(negedge clk);
            rx_data = f[i];
            rx_clk  = 1'b0;
            repeat (3) @(negedge clk);
            rx_clk = 1'b1;
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        rx_clk  = 1'b0;
        rx_data = 1'b0;
    endtask

    task automatic do_frame(input string tag, input frame_t f, output frame_t got);
        frame_t exp;
        int     t;
        model(f, exp);
        send_bits(f, F);
        t = 0;
        while (cap_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_resp"}, W'(cap_q.size() != 0), W'(1));
        got = '0;
        if (cap_q.size() != 0) begin
            got = cap_q.pop_front();
            check_val({tag, "_fwd"}, W'(got), W'(exp));
        end
        check_state(tag);
    endtask

    initial begin
        frame_t          f, got;
        logic [BITS-1:0] pay;
        logic [7:0]      sel;
        logic [14:0]     addr;
        logic            w;
        logic [CH-1:0]   tgl_before;
        int              kind, t;

        model_reset();
        rand_inputs();
        repeat (4) @(negedge clk);
        check_val("rst_txclk",  W'(tx_clk),  W'(0));
        check_val("rst_txdata", W'(tx_data), W'(0));
        check_state("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Enumeration
        pay = rand_pay();
        pay[14:0] = 15'h1234;
        do_frame("enum", mk(pay, 8'h00, 15'h7FFF, 1'b0), got);
        check_val("enum_node_addr", W'(node_address), W'(15'h1234));
        check_val("enum_fwd_v", W'(got[24 +: 15]), W'(15'h1235));

        // Reads
        do_frame("rd_id", mk(rand_pay(), 8'h00, 15'h1234, 1'b0), got);
        check_val("rd_id_pay", W'(got[F-1:24]), W'(identity));
        f = mk(rand_pay(), 8'h03, 15'h1234, 1'b0);
        do_frame("rd_ch2", f, got);
        check_val("rd_ch2_pay", W'(got[F-1:24]), W'(debug_outgoing_data[2*BITS +: BITS]));
        check_val("rd_ch2_hdr", W'(got[23:0]), W'(f[23:0]));

        // Write channel 3
        pay = 128'hAABBCCDD_EEFF0011_22334455_66778899;
        f = mk(pay, 8'h04, 15'h1234, 1'b1);
        do_frame("wr_ch3", f, got);
        check_val("wr_ch3_data", W'(debug_incoming_data[3*BITS +: BITS]), W'(pay));
        check_val("wr_ch3_tgl", W'(debug_incoming_tgl), W'(4'b1000));
        check_val("wr_ch3_ident", W'(got), W'(f));

        // Frames that must pass through untouched
        tgl_before = debug_incoming_tgl;
        f = mk(rand_pay(), 8'h01, 15'h1233, 1'b0);
        do_frame("rd_other", f, got);
        check_val("rd_other_ident", W'(got), W'(f));
        f = mk(rand_pay(), 8'h09, 15'h1234, 1'b0);
        do_frame("rd_sel9", f, got);
        check_val("rd_sel9_ident", W'(got), W'(f));
        f = mk(rand_pay(), 8'h00, 15'h1234, 1'b1);
        do_frame("wr_sel0", f, got);
        check_val("wr_sel0_ident", W'(got), W'(f));
        check_val("pass_tgl", W'(debug_incoming_tgl), W'(tgl_before));

        // Status read
        f = mk(rand_pay(), 8'hFE, 15'h1234, 1'b0);
        do_frame("status", f, got);
`ifdef SERIAL_DEBUG_MC_STATUS_EN
        check_val("status_word", W'(got[24 +: 32]), W'(32'h04000001));
        check_val("status_hi", W'(got[F-1:56]), W'(0));
`else
        check_val("status_ident", W'(got), W'(f));
`endif

        // Stalled partial frame, then a valid read
        send_bits(mk(rand_pay(), 8'h02, 15'h1234, 1'b0), 40);
        repeat (300) @(negedge clk);
        check_val("partial_no_out", W'(cap_q.size()), W'(0));
        do_frame("after_partial", mk(rand_pay(), 8'h02, 15'h1234, 1'b0), got);

        // Randomised traffic
        for (int i = 0; i < 14; i++) begin
            rand_inputs();
            pay  = rand_pay();
            kind = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0:       sel = 8'h00;
                1:       sel = 8'($urandom_range(1, CH));
                2:       sel = 8'hFE;
                default: sel = 8'($urandom_range(0, 255));
            endcase
            w    = 1'($urandom_range(0, 1));
            addr = m_addr;
            case (kind)
                0: w = 1'b0;
                1: w = 1'b1;
                2: addr = m_addr ^ 15'($urandom_range(1, 255));
                3: addr = 15'h7FFF;
                default: addr = m_addr;
            endcase
            do_frame($sformatf("rnd%0d", i), mk(pay, sel, addr, w), got);
        end

        check_val("tx_timing_viol", W'(tx_viol), W'(0));

        // Reset in the middle of a retransmission
        send_bits(mk(rand_pay(), 8'h01, m_addr, 1'b0), F);
        t = 0;
        while (cap_n < 50 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val("midtx_reached", W'(cap_n >= 50), W'(1));
        rst_n = 1'b0;
        #1;
        check_val("midrst_txclk",  W'(tx_clk),  W'(0));
        check_val("midrst_txdata", W'(tx_data), W'(0));
        model_reset();
        check_state("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        check_val("midrst_no_out", W'(cap_q.size()), W'(0));
        check_val("midrst_idle", W'({tx_clk, tx_data}), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_debug_mc.md
# serial_debug_mc

Multi-channel serial debug node: the parametrised successor of the single-register serial debug node. It sits on the daisy-chained serial debug ring driven by the UART debug bridge. It exposes CHANNELS independent BITS-wide probe/control registers per node, selected by a channel byte in an extended frame header. It is a store-and-forward node: each frame is fully received, decoded, optionally modified, then retransmitted downstream.

## Interface
- BITS, 128, payload width; must be ≥32 and a multiple of 8.
- CHANNELS, 4, number of probe/control channels; legal range 1..253.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- prescaler  in  8  link half-bit length minus 1; must be ≥1.
- rx_data, rx_clk  in  1  upstream link.
- tx_data, tx_clk  out  1  downstream link.
- identity  in  BITS  value returned by identity reads.
- debug_outgoing_data  in  CHANNELS*BITS  channel k is at [k*BITS +: BITS].
- debug_incoming_data  out  CHANNELS*BITS  written values, same packing.
- debug_incoming_tgl  out  CHANNELS  bit k toggles on each accepted write to channel k.
- node_address  out  15  address claimed at enumeration.
- address_valid  out  1  node holds an address.

## Operation
- Frame: F = BITS+24 bits, sent MSB first. Bit [0] is W (1 = write). Bits [15:1] are addr. Bits [23:16] are sel. Bits [F-1:24] are payload.
- Enumeration (addr = 0x7FFF): v = payload[14:0].
  - If v ≠ 0x7FFF: node_address ← v and address_valid ← 1.
  - Forward with payload[14:0] = v+1 (15-bit wrap). All other bits are unchanged.
- Read (W=0, address_valid, addr = node_address):
  - sel 0x00: payload ← identity.
  - sel 1..CHANNELS: payload ← channel sel−1.
  - Other sel values: unchanged. Header is always forwarded unchanged.
- Write (W=1, address match, sel 1..CHANNELS): debug_incoming_data channel sel−1 ← payload, and debug_incoming_tgl[sel−1] inverts. The frame is forwarded unchanged. Out-of-range sel has no effect.
- Any other frame: forwarded bit-identical.
- Rx path:
  - rx_clk and rx_data pass through 2-flop synchronisers.
  - Data is sampled on the synced rising edge of rx_clk and shifted into an F-bit register.
  - If the bit count is nonzero and no rising edge arrives for 64*(prescaler+1) clk cycles, the partial frame is discarded.
- Buffering: one rx register and one tx register.
  - On frame completion with tx idle, the decoded frame loads into tx.
  - If tx is busy, the new frame is dropped and drop_count increments, saturating at 255.
- write_count: 16-bit counter of accepted writes; wraps.

## Timing
- Link bit = 2*(prescaler+1) clk cycles. tx_clk is low for prescaler+1 cycles, then high for prescaler+1 cycles.
- tx_data changes only at the start of the low phase.
- prescaler is sampled at the start of each tx bit.
- Link idle state: tx_clk=0, tx_data=0.
- Decode happens in the cycle after the last bit is sampled. The tx low phase of bit F-1 begins the next cycle.
- Upstream rising edge to first downstream bit: ≤ F link bits + 4 clk cycles.
- Register and toggle updates for a write take effect in the decode cycle.
- Reset values: tx_clk 0, tx_data 0, debug_incoming_data 0, debug_incoming_tgl 0, node_address 0, address_valid 0, counters 0.
- Reset asserted mid-frame aborts rx and tx immediately; the link returns to idle.
- Re-enumeration overwrites node_address.
- A simultaneous frame completion and tx finish in the same cycle counts as tx idle; the frame is not dropped.

## Configuration
- SERIAL_DEBUG_MC_STATUS_EN defined:
  - A read with sel 0xFE returns status in payload[31:0]: {CHANNELS[7:0], drop_count[7:0], write_count[15:0]}. All higher payload bits read 0.
- Undefined:
  - sel 0xFE is an out-of-range read and is forwarded unchanged.
  - drop_count and write_count are not implemented.

## Test plan
- Test setup: BITS=128, CHANNELS=4, prescaler=2.
- Reset, then enumeration frame with addr=0x7FFF and payload[14:0]=0x1234 → node_address=0x1234, address_valid=1, forwarded payload[14:0]=0x1235.
- Read addr=0x1234, sel=0x00 → forwarded payload=identity. Read sel=0x03 → payload=channel 2 outgoing value; header unchanged.
- Write addr=0x1234, sel=0x04, payload=0xAABBCCDD_EEFF0011_22334455_66778899 → channel 3 incoming equals payload; tgl=4'b1000; frame forwarded bit-identical.
- Reads to addr=0x1233 and sel=0x09, and a write with sel=0x00 → frames forwarded unchanged; no tgl change.
- With SERIAL_DEBUG_MC_STATUS_EN, after one write: read sel=0xFE → payload[31:0]=0x04000001. Without the macro → frame unchanged.
- Stop rx_clk after 40 bits for 300 cycles, then send a valid read → partial frame discarded; the read response is correct.
